// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap line and its shift register.
package fir_pkg;

  localparam int FIR_NTAPS  = 6;
  localparam int FIR_DATA_W = 16;

  typedef logic [FIR_DATA_W-1:0] sample_t;
  typedef logic [2:0]            fill_t;

endpackage : fir_pkg

// File: rtl/fir_tap_shreg.sv
// DATA_W-wide, DEPTH-deep delay line with enable and synchronous clear.
// o_taps[0] holds the newest sample, o_taps[DEPTH-1] the oldest.
module fir_tap_shreg
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_NTAPS
) (
  input  logic                          clk,
  input  logic                          i_clr,
  input  logic                          i_en,
  input  logic [DATA_W-1:0]             i_din,
  output logic [DEPTH-1:0][DATA_W-1:0]  o_taps
);

  logic [DEPTH-1:0][DATA_W-1:0] r_taps;

  // Clear outranks shift so a flush discards a same-cycle sample.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_taps <= '0;
    end else if (i_en) begin
      r_taps <= {r_taps[DEPTH-2:0], i_din};
    end
  end

  assign o_taps = r_taps;

endmodule : fir_tap_shreg

// File: rtl/fir_tap_line.sv
// Serial-to-parallel window feeder for the 6-tap FIR with valid/ready on both sides.
// Optional FIR_TAP_ZERO_PAD_EN: present a (zero-padded) window after every accept.
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEQ_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_tap_1,
  output logic [DATA_W-1:0] out_tap_2,
  output logic [DATA_W-1:0] out_tap_3,
  output logic [DATA_W-1:0] out_tap_4,
  output logic [DATA_W-1:0] out_tap_5,
  output logic [DATA_W-1:0] out_tap_6,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [2:0]        fill
);

  logic                                w_clr;
  logic                                w_in_ready;
  logic                                w_accept;
  logic                                w_full_next;
  logic [FIR_NTAPS-1:0][DATA_W-1:0]    w_taps;

  fill_t             r_fill;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_out_valid;

  assign w_clr      = rst | flush;
  assign w_in_ready = !rst && !flush && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Window becomes complete when this accept brings the count to FIR_NTAPS.
  assign w_full_next = ({1'b0, r_fill} + 4'd1) >= 4'(FIR_NTAPS);

  fir_tap_shreg #(
    .DATA_W (DATA_W),
    .DEPTH  (FIR_NTAPS)
  ) u_shreg (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_en   (w_accept),
    .i_din  (in_data),
    .o_taps (w_taps)
  );

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_fill      <= '0;
      r_seq       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fill <= (r_fill == fill_t'(FIR_NTAPS)) ? r_fill : r_fill + 3'd1;
        r_seq  <= r_seq + 1'b1;
      end
`ifdef FIR_TAP_ZERO_PAD_EN
      if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
`else
      if (w_accept && w_full_next) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_seq   = r_seq;
  assign fill      = r_fill;
  assign out_tap_1 = w_taps[0];
  assign out_tap_2 = w_taps[1];
  assign out_tap_3 = w_taps[2];
  assign out_tap_4 = w_taps[3];
  assign out_tap_5 = w_taps[4];
  assign out_tap_6 = w_taps[5];

endmodule : fir_tap_line

// File: doc/fir_tap_line.md
Name: fir_tap_line

Overview:
- Upstream feeder for the 6-tap FIR multiply/add graph.
- Converts a serial sample stream into six parallel tap values, newest in tap 1 and oldest in tap 6. These drive multiplier data inputs 1..6.
- Uses a valid/ready handshake on both sides. Holds the presented window stable until the downstream consumer accepts it.

Parameters:
- DATA_W, 16, width of each sample and each tap output.
- SEQ_W, 8, width of the sample sequence counter; wraps modulo 2^SEQ_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of the window; does not affect configuration.
- in_data  input  DATA_W  incoming sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_tap_1 .. out_tap_6  output  DATA_W each  window; out_tap_1 is the newest sample, out_tap_6 the oldest.
- out_valid  output  1  window is complete and not yet consumed.
- out_ready  input  1  downstream consumes the window.
- out_seq  output  SEQ_W  count of samples accepted since reset/flush, mod 2^SEQ_W; it is the index of out_tap_1 plus one.
- fill  output  3  number of valid samples in window, 0..6, saturating.

Behaviour:
- Reset (rst=1 at edge): all taps 0, fill 0, out_seq 0, out_valid 0. in_ready is 0 while rst is high.
- in_ready = !rst && !flush && (!out_valid || out_ready). It is combinational and has no dependency on in_valid.
- accept = in_valid && in_ready.
- On accept:
  - tap_k <= tap_(k-1) for k = 6..2, and tap_1 <= in_data.
  - fill <= min(fill+1, 6).
  - out_seq <= out_seq+1, wrapping from 2^SEQ_W-1 to 0.
- Latency: 1 cycle from accept to the updated window on the outputs.
- out_valid next value, in priority order:
  - 0 if rst or flush;
  - 1 if accept and fill+1 >= 6;
  - 0 if out_ready;
  - otherwise hold.
- Simultaneous consume and accept (out_valid=1, out_ready=1, in_valid=1): the window advances and out_valid stays 1. This gives one window per cycle at full throughput.
- Backpressure: out_valid=1 with out_ready=0 holds the taps, out_seq and fill unchanged, and in_ready=0.
- The first out_valid occurs one cycle after the 6th accepted sample. Before that, the taps shift but out_valid stays 0.
- flush:
  - Clears taps, fill, out_seq and out_valid on the next edge.
  - Wins over a same-cycle accept; the sample presented that cycle is not accepted (in_ready=0).
  - A window pending under backpressure is discarded.
- rst mid-stream behaves identically to flush and also forces in_ready low while asserted.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: FIR_TAP_ZERO_PAD_EN.
- Defined:
  - out_valid asserts one cycle after every accept, including the first. Unfilled taps read 0, since they are cleared by reset/flush.
  - fill still counts 0..6.
- Undefined: out_valid requires fill = 6 as described above.

Decomposition:
- Shared package fir_pkg holds:
  - constant FIR_NTAPS = 6;
  - the sample type (DATA_W-wide logic);
  - the fill type (3 bits).
- One natural sub-module, fir_tap_shreg: a DATA_W-wide, FIR_NTAPS-deep shift register with an enable and a synchronous clear.
- fir_tap_line adds the handshake, the fill/seq counters and the valid logic around fir_tap_shreg.

Test Plan:
- Fill: rst, then in_valid=1 continuously with data 1,2,3,4,5,6 and out_ready=1. Expect out_valid first high the cycle after 6 is accepted, with taps 1..6 = 6,5,4,3,2,1, out_seq=6, fill=6.
- Streaming: continue with sample 7 and out_ready=1. Expect out_valid held high and taps = 7,6,5,4,3,2, one window per cycle with no bubbles.
- Backpressure: while full, drop out_ready for 3 cycles with in_valid=1 and data 8. Expect in_ready=0, taps frozen at 7..2 and out_seq frozen. On out_ready=1, sample 8 is accepted that same cycle.
- Flush mid-stream: assert flush together with in_valid=1 and data 9. Expect the sample not accepted, then taps=0, fill=0, out_seq=0, out_valid=0. The next six samples are needed before out_valid rises again.
- Sequence wrap: with SEQ_W=8, stream 260 samples. Expect out_seq to wrap 255->0 and read 4 after the last sample.
- Zero-pad (macro defined): after rst, accept 0x1234. Expect out_valid=1 next cycle, out_tap_1=0x1234, other taps 0, fill=1.
